ps2_scan_decoder: RTL and testbench

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_scan_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from an upstream FIFO, strips E0/F0
// prefixes and presents one registered key event at a time with a valid/ack
// handshake. Tracks shift and caps-lock modifier state.
// Optional macro PS2_ASCII_EN adds a US-layout ASCII translation of make events;
// without it key_ascii is tied to 0x00.
module ps2_scan_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_data,
    input  logic       code_ready,
    output logic       code_read,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic [7:0] key_ascii,
    output logic       shift,
    output logic       caps
);

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } state_e;

    state_e     state_q, state_d;
    logic       key_valid_q;
    logic [7:0] key_code_q;
    logic       key_ext_q, key_release_q;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic       caps_q, caps_d;
    logic       caps_held_q, caps_held_d;

    logic       emit, emit_ext, emit_rel;
    logic       is_filler;

    // Never pop while an event is pending or during reset.
    assign code_read = code_ready & ~key_valid_q & ~rst;

    // Keyboard housekeeping bytes that carry no key information in IDLE.
    always_comb begin
        case (code_data)
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF, 8'hE1: is_filler = 1'b1;
            default:                                         is_filler = 1'b0;
        endcase
    end

    // Prefix FSM next-state and event emission on each popped byte.
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (code_read) begin
            case (state_q)
                StIdle: begin
                    if (code_data == 8'hF0) begin
                        state_d = StBrk;
                    end else if (code_data == 8'hE0) begin
                        state_d = StExt;
                    end else if (!is_filler) begin
                        emit = 1'b1;
                    end
                end
                StBrk: begin
                    state_d = StIdle;
                    if (code_data != 8'hF0 && code_data != 8'hE0) begin
                        emit     = 1'b1;
                        emit_rel = 1'b1;
                    end
                end
                StExt: begin
                    if (code_data == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d = StIdle;
                        if (code_data != 8'hE0) begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                        end
                    end
                end
                StExtBrk: begin
                    state_d = StIdle;
                    if (code_data != 8'hF0 && code_data != 8'hE0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_rel = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Modifier tracking; only non-extended events affect shift/caps.
    always_comb begin
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (emit && !emit_ext) begin
            if (code_data == 8'h12) shift_l_d = ~emit_rel;
            if (code_data == 8'h59) shift_r_d = ~emit_rel;
            if (code_data == 8'h58) begin
                if (emit_rel) begin
                    caps_held_d = 1'b0;
                end else if (!caps_held_q) begin
                    // Auto-repeat makes arrive with caps_held set and are ignored.
                    caps_d      = ~caps_q;
                    caps_held_d = 1'b1;
                end
            end
        end
    end

    // State, event and modifier registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            shift_l_q     <= 1'b0;
            shift_r_q     <= 1'b0;
            caps_q        <= 1'b0;
            caps_held_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            if (emit) begin
                key_valid_q   <= 1'b1;
                key_code_q    <= code_data;
                key_ext_q     <= emit_ext;
                key_release_q <= emit_rel;
            end else if (key_valid_q && key_ack) begin
                key_valid_q <= 1'b0;
            end
        end
    end

`ifdef PS2_ASCII_EN
    logic [7:0] ascii_d, ascii_q;
    logic [7:0] letter;
    logic [7:0] digit_plain, digit_shift;
    logic       is_digit;

    // US-layout lookup; letters are returned lowercase and raised later.
    always_comb begin
        letter      = 8'h00;
        digit_plain = 8'h00;
        digit_shift = 8'h00;
        is_digit    = 1'b0;
        case (code_data)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            8'h45: begin is_digit = 1'b1; digit_plain = 8'h30; digit_shift = 8'h29; end
            8'h16: begin is_digit = 1'b1; digit_plain = 8'h31; digit_shift = 8'h21; end
            8'h1E: begin is_digit = 1'b1; digit_plain = 8'h32; digit_shift = 8'h40; end
            8'h26: begin is_digit = 1'b1; digit_plain = 8'h33; digit_shift = 8'h23; end
            8'h25: begin is_digit = 1'b1; digit_plain = 8'h34; digit_shift = 8'h24; end
            8'h2E: begin is_digit = 1'b1; digit_plain = 8'h35; digit_shift = 8'h25; end
            8'h36: begin is_digit = 1'b1; digit_plain = 8'h36; digit_shift = 8'h5E; end
            8'h3D: begin is_digit = 1'b1; digit_plain = 8'h37; digit_shift = 8'h26; end
            8'h3E: begin is_digit = 1'b1; digit_plain = 8'h38; digit_shift = 8'h2A; end
            8'h46: begin is_digit = 1'b1; digit_plain = 8'h39; digit_shift = 8'h28; end
            default: ;
        endcase
    end

    // Translate make, non-extended events using modifier state before this event.
    always_comb begin
        ascii_d = 8'h00;
        if (!emit_ext && !emit_rel) begin
            if (letter != 8'h00) begin
                ascii_d = (shift ^ caps_q) ? (letter - 8'h20) : letter;
            end else if (is_digit) begin
                ascii_d = shift ? digit_shift : digit_plain;
            end else begin
                case (code_data)
                    8'h29:   ascii_d = 8'h20;
                    8'h5A:   ascii_d = 8'h0D;
                    8'h66:   ascii_d = 8'h08;
                    8'h0D:   ascii_d = 8'h09;
                    8'h76:   ascii_d = 8'h1B;
                    default: ascii_d = 8'h00;
                endcase
            end
        end
    end

    // ASCII register loads alongside the other event fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            ascii_q <= 8'h00;
        end else if (emit) begin
            ascii_q <= ascii_d;
        end
    end

    assign key_ascii = ascii_q;
`else
    assign key_ascii = 8'h00;
`endif

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
    assign shift       = shift_l_q | shift_r_q;
    assign caps        = caps_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed scan-code sequences followed
// by random byte streams, compared cycle by cycle against a byte-stream model.
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_data = 8'h00;
    logic       code_ready = 1'b0;
    logic       code_read;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic [7:0] key_ascii;
    logic       shift;
    logic       caps;

    always #5 clk = ~clk;

    ps2_scan_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .code_data   (code_data),
        .code_ready  (code_ready),
        .code_read   (code_read),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_ascii   (key_ascii),
        .shift       (shift),
        .caps        (caps)
    );

    int total = 0;
    int bad   = 0;

    // Upstream FIFO contents.
    logic [7:0] fifo[$];

    // Reference model state.
    bit       pend_ext = 0, pend_brk = 0;
    bit       m_valid = 0, m_ext = 0, m_rel = 0;
    bit [7:0] m_code = 0, m_ascii = 0;
    bit       m_sl = 0, m_sr = 0, m_caps = 0, m_held = 0;

    logic [7:0] letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
    logic [7:0] digit_sc[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};
    logic [7:0] digit_sym[10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                  8'h2A, 8'h28};
    logic [7:0] fixed_sc[5]   = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] fixed_asc[5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_ext = 0; pend_brk = 0;
        m_valid = 0; m_ext = 0; m_rel = 0; m_code = 0; m_ascii = 0;
        m_sl = 0; m_sr = 0; m_caps = 0; m_held = 0;
    endtask

    // Key event generated from a fully prefixed byte sequence.
    task automatic model_event(input logic [7:0] b, input bit ext, input bit rel);
        bit [7:0] a;
        a = 8'h00;
`ifdef PS2_ASCII_EN
        if (!ext && !rel) begin
            for (int i = 0; i < 26; i++)
                if (b == letter_sc[i]) a = 8'((((m_sl | m_sr) ^ m_caps) ? 8'h41 : 8'h61) + i);
            for (int i = 0; i < 10; i++)
                if (b == digit_sc[i]) a = (m_sl | m_sr) ? digit_sym[i] : 8'(8'h30 + i);
            for (int i = 0; i < 5; i++)
                if (b == fixed_sc[i]) a = fixed_asc[i];
        end
`endif
        m_valid = 1; m_code = b; m_ext = ext; m_rel = rel; m_ascii = a;
        if (!ext) begin
            if (b == 8'h12) m_sl = !rel;
            if (b == 8'h59) m_sr = !rel;
            if (b == 8'h58) begin
                if (rel) m_held = 0;
                else if (!m_held) begin
                    m_caps = !m_caps;
                    m_held = 1;
                end
            end
        end
    endtask

    // Consume one byte from the stream.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            if (pend_brk) begin pend_ext = 0; pend_brk = 0; end
            else pend_brk = 1;
        end else if (b == 8'hE0) begin
            if (pend_ext || pend_brk) begin pend_ext = 0; pend_brk = 0; end
            else pend_ext = 1;
        end else if (!pend_ext && !pend_brk &&
                     (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF, 8'hE1})) begin
            // housekeeping byte, dropped
        end else begin
            model_event(b, pend_ext, pend_brk);
            pend_ext = 0;
            pend_brk = 0;
        end
    endtask

    // One clock: drive, check pop strobe, advance model, check registered outputs.
    task automatic cycle(input bit ack);
        bit         exp_read, dut_pop;
        logic [7:0] b;
        key_ack    = ack;
        code_ready = (fifo.size() > 0);
        code_data  = code_ready ? fifo[0] : 8'h00;
        b          = code_data;
        @(negedge clk);
        exp_read = code_ready && !m_valid && !rst;
        chk("code_read", {7'b0, code_read}, {7'b0, exp_read});
        dut_pop = (code_read === 1'b1);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (m_valid && ack) m_valid = 0;
            if (exp_read) model_byte(b);
        end
        if (dut_pop && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        chk("key_valid",   {7'b0, key_valid},   {7'b0, m_valid});
        chk("key_code",    key_code,            m_code);
        chk("key_ext",     {7'b0, key_ext},     {7'b0, m_ext});
        chk("key_release", {7'b0, key_release}, {7'b0, m_rel});
        chk("key_ascii",   key_ascii,           m_ascii);
        chk("shift",       {7'b0, shift},       {7'b0, m_sl | m_sr});
        chk("caps",        {7'b0, caps},        {7'b0, m_caps});
    endtask

    task automatic run(input int n, input bit ack);
        for (int i = 0; i < n; i++) cycle(ack);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 11))
            0, 1:    return 8'hF0;
            2:       return 8'hE0;
            3:       return 8'h12;
            4:       return 8'h59;
            5:       return 8'h58;
            6:       return 8'h1C;
            7:       return 8'h16;
            8:       return 8'hAA;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state.
        rst = 1'b1;
        run(2, 1'b0);
        rst = 1'b0;
        cycle(1'b0);

        // 1C make, 1C break with ack held high.
        fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        run(8, 1'b1);
        chk("drain_1c", 8'(fifo.size()), 8'd0);

        // Shifted letter.
        fifo.push_back(8'h12); fifo.push_back(8'h1C);
        fifo.push_back(8'hF0); fifo.push_back(8'h12);
        run(10, 1'b1);

        // Extended make and break.
        fifo.push_back(8'hE0); fifo.push_back(8'h75);
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
        run(10, 1'b1);

        // Caps lock with auto-repeat, then a letter.
        fifo.push_back(8'h58); fifo.push_back(8'h58); fifo.push_back(8'hF0);
        fifo.push_back(8'h58); fifo.push_back(8'h1C);
        run(12, 1'b1);
        // Restore caps off for later directed steps.
        fifo.push_back(8'h58); fifo.push_back(8'hF0); fifo.push_back(8'h58);
        run(8, 1'b1);

        // Back-pressure: one pop per acknowledge.
        fifo.push_back(8'h1C); fifo.push_back(8'h32);
        fifo.push_back(8'h21); fifo.push_back(8'h23);
        run(6, 1'b0);
        chk("hold_pops", 8'(fifo.size()), 8'd3);
        cycle(1'b1);
        run(3, 1'b0);
        chk("ack_pop", 8'(fifo.size()), 8'd2);
        run(8, 1'b1);
        chk("drain_bp", 8'(fifo.size()), 8'd0);

        // Reset discards a pending E0 prefix; housekeeping bytes dropped.
        fifo.push_back(8'hE0);
        run(2, 1'b1);
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        fifo.push_back(8'h16); fifo.push_back(8'hAA); fifo.push_back(8'hFA);
        run(8, 1'b1);

        // Illegal prefix combinations.
        fifo.push_back(8'hF0); fifo.push_back(8'hE0); fifo.push_back(8'h1C);
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'hF0);
        fifo.push_back(8'h1C);
        run(14, 1'b1);

        // Random streams with random acknowledge and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if (fifo.size() < 3 && $urandom_range(0, 2) != 0) fifo.push_back(rand_byte());
            rst = ($urandom_range(0, 149) == 0);
            cycle($urandom_range(0, 2) != 0);
        end
        rst = 1'b0;
        run(10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
